// File: rtl/cdc_hs_tx_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared definitions for the four-phase req/ack CDC handshake. The source-side
// transmitter (cdc_hs_tx) and the destination-side receiver both use the same
// FSM state constants, so state dumps read identically on either side.
// -----------------------------------------------------------------------------
package cdc_pkg;

    // 2-bit FSM state encoding (plain constants so legacy code can share them)
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ_HI = 2'd1;
    localparam logic [1:0] REQ_LO = 2'd2;

    // True while the FSM is waiting on the far side (either handshake phase)
    function automatic logic is_waiting(input logic [1:0] state);
        return (state == REQ_HI) || (state == REQ_LO);
    endfunction

endpackage

// File: rtl/cdc_hs_tx_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Single-bit multi-flop synchroniser. Brings an asynchronous level into the
// i_clk domain after NUM_STAGES rising edges.
// Ports:
//   i_clk  in  destination clock
//   i_rst  in  asynchronous active-high reset (chain clears to 0)
//   i_d    in  asynchronous input level
//   o_q    out synchronised level (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_chain
    import cdc_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [NUM_STAGES-1:0] r_chain;

    // Shift the asynchronous level through the flop chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= {NUM_STAGES{1'b0}};
        end else begin
            r_chain <= {r_chain[NUM_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[NUM_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// -----------------------------------------------------------------------------
// cdc_hs_tx
// Source-domain end of a four-phase req/ack handshake carrying a multi-bit
// word across a clock-domain boundary. A word is accepted on valid/ready, held
// stable on o_cdc_data and announced with o_cdc_req; the destination's
// acknowledge is synchronised and walked through the full four-phase cycle
// before the next word may be accepted. One word in flight, no buffering.
// Ports:
//   i_clk          in  source clock (rising edge)
//   i_rst          in  asynchronous active-high reset
//   i_src_data     in  word to transfer
//   i_src_valid    in  i_src_data is valid
//   o_src_ready    out block can accept a word this cycle
//   o_cdc_data     out registered word, stable while req or synchronised ack high
//   o_cdc_req      out registered four-phase request
//   i_cdc_ack      in  asynchronous acknowledge from the destination domain
//   o_xfer_done    out one-cycle pulse when a handshake completes
//   o_timeout_err  out sticky flag: a handshake phase lasted TIMEOUT_CYCLES
//   i_err_clr      in  synchronous clear of o_timeout_err (a new set wins)
// -----------------------------------------------------------------------------
module cdc_hs_tx
    import cdc_pkg::*;
#(
    parameter int BUS_WIDTH      = 8,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [BUS_WIDTH-1:0] i_src_data,
    input  logic                 i_src_valid,
    output logic                 o_src_ready,
    output logic [BUS_WIDTH-1:0] o_cdc_data,
    output logic                 o_cdc_req,
    input  logic                 i_cdc_ack,
    output logic                 o_xfer_done,
    output logic                 o_timeout_err,
    input  logic                 i_err_clr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [1:0]           r_state;
    logic [BUS_WIDTH-1:0] r_data;
    logic                 r_req;
    logic                 r_done;

    logic                 w_ack_s;
    logic [1:0]           w_state_nxt;
    logic                 w_load;
    logic                 w_req_nxt;
    logic                 w_done_nxt;
    logic                 w_src_ready;

    sync_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_cdc_ack),
        .o_q   (w_ack_s)
    );

    // A late ack from an aborted handshake must drain before a new accept
    assign w_src_ready = (r_state == IDLE) && !w_ack_s;

    // Next-state and output decode for the four-phase handshake
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_req_nxt   = r_req;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_src_valid && w_src_ready) begin
                    w_state_nxt = REQ_HI;
                    w_load      = 1'b1;
                    w_req_nxt   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ_HI: begin
                // Only a rising ack advances; a falling glitch here is ignored
                if (w_ack_s) begin
                    w_state_nxt = REQ_LO;
                    w_req_nxt   = 1'b0;
                end else begin
                    w_state_nxt = REQ_HI;
                end
            end
            REQ_LO: begin
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = REQ_LO;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // Handshake state, request and completion pulse registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Data register: written only on an accept so it is frozen during a transfer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= {BUS_WIDTH{1'b0}};
        end else if (w_load) begin
            r_data <= i_src_data;
        end else begin
            r_data <= r_data;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_err;
            logic             w_waiting;
            logic             w_hit;

            assign w_waiting = is_waiting(r_state);
            assign w_hit     = w_waiting && (r_cnt == CNT_LAST);

            // Per-phase wait counter; restarts on every state change, saturates at the limit
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_cnt <= {CNT_W{1'b0}};
                end else if ((w_state_nxt != r_state) || !w_waiting) begin
                    r_cnt <= {CNT_W{1'b0}};
                end else if (!w_hit) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_cnt <= r_cnt;
                end
            end

            // Sticky error; a set in the same cycle as a clear takes priority
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_err <= 1'b0;
                end else if (w_hit) begin
                    r_err <= 1'b1;
                end else if (i_err_clr) begin
                    r_err <= 1'b0;
                end else begin
                    r_err <= r_err;
                end
            end

            assign o_timeout_err = r_err;
        end else begin : g_no_timeout
            assign o_timeout_err = 1'b0;
        end
    endgenerate

    assign o_src_ready = w_src_ready;
    assign o_cdc_data  = r_data;
    assign o_cdc_req   = r_req;
    assign o_xfer_done = r_done;

endmodule
